// File: rtl/scan_bcd_conv.sv
// Sequential binary-to-BCD (double-dabble) converter feeding the seven-segment scan driver.
// Optional two's-complement input handling is enabled by defining SCAN_BCD_SIGNED_EN.
module scan_bcd_conv #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  scan_clk,
  input  logic                  scan_rst,
  input  logic                  scan_cs,
  input  logic                  scan_write,
  input  logic [WIDTH-1:0]      scanwdata,
  output logic                  busy,
  output logic                  bcd_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [2:0]            nz_digits,
  output logic                  neg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t                state;
  logic [WIDTH-1:0]      bin;
  logic [4*DIGITS-1:0]   acc;
  logic [CW-1:0]         cnt;
  logic                  cur_neg;
  logic                  pend;
  logic [WIDTH-1:0]      pend_val;
  logic                  pend_neg;

  logic                  wr;
  logic                  in_neg;
  logic [WIDTH-1:0]      in_mag;
  logic [4*DIGITS-1:0]   acc_adj;
  logic [4*DIGITS-1:0]   acc_sh;
  logic [WIDTH-1:0]      bin_sh;

  assign wr = scan_cs && scan_write;

`ifdef SCAN_BCD_SIGNED_EN
  // Magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
  assign in_neg = scanwdata[WIDTH-1];
  assign in_mag = in_neg ? (~scanwdata + 1'b1) : scanwdata;
`else
  assign in_neg = 1'b0;
  assign in_mag = scanwdata;
`endif

  // Per-digit add-3 correction, no carry between digits, then one left shift.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_sh = (acc_adj << 1) | {{(4*DIGITS-1){1'b0}}, bin[WIDTH-1]};
    bin_sh = bin << 1;
  end

  function automatic logic [2:0] nz_of(input logic [4*DIGITS-1:0] v);
    nz_of = 3'd1;
    for (int i = 1; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd0)
        nz_of = 3'(i + 1);
    end
  endfunction

  always_ff @(posedge scan_clk or posedge scan_rst) begin
    if (scan_rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
      bcd       <= '0;
      nz_digits <= 3'd1;
      neg       <= 1'b0;
      bin       <= '0;
      acc       <= '0;
      cnt       <= '0;
      cur_neg   <= 1'b0;
      pend      <= 1'b0;
      pend_val  <= '0;
      pend_neg  <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (wr) begin
            bin     <= in_mag;
            cur_neg <= in_neg;
            acc     <= '0;
            cnt     <= '0;
            state   <= SHIFT;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          acc <= acc_sh;
          bin <= bin_sh;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            bcd       <= acc_sh;
            nz_digits <= nz_of(acc_sh);
            neg       <= cur_neg;
            bcd_valid <= 1'b1;
            cnt       <= '0;
            // A write landing on the completion edge outranks anything pending.
            if (wr) begin
              bin     <= in_mag;
              cur_neg <= in_neg;
              acc     <= '0;
              pend    <= 1'b0;
            end else if (pend) begin
              bin     <= pend_val;
              cur_neg <= pend_neg;
              acc     <= '0;
              pend    <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (wr) begin
            pend_val <= in_mag;
            pend_neg <= in_neg;
            pend     <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_bcd_conv.sv
// Self-checking bench for scan_bcd_conv; reference values come from decimal arithmetic on the written value.
module tb_scan_bcd_conv;

  logic        scan_clk = 1'b0;
  logic        scan_rst = 1'b1;
  logic        scan_cs = 1'b0;
  logic        scan_write = 1'b0;
  logic [15:0] scanwdata = '0;
  logic        busy;
  logic        bcd_valid;
  logic [19:0] bcd;
  logic [2:0]  nz_digits;
  logic        neg;

  int n_cmp = 0;
  int n_err = 0;

  always #5 scan_clk = ~scan_clk;

  scan_bcd_conv #(.WIDTH(16), .DIGITS(5)) dut (
    .scan_clk  (scan_clk),
    .scan_rst  (scan_rst),
    .scan_cs   (scan_cs),
    .scan_write(scan_write),
    .scanwdata (scanwdata),
    .busy      (busy),
    .bcd_valid (bcd_valid),
    .bcd       (bcd),
    .nz_digits (nz_digits),
    .neg       (neg)
  );

  function automatic int mag_of(input logic [15:0] raw);
    int v;
    v = raw;
`ifdef SCAN_BCD_SIGNED_EN
    if (raw[15]) v = 65536 - v;
`endif
    return v;
  endfunction

  function automatic logic [31:0] neg_of(input logic [15:0] raw);
`ifdef SCAN_BCD_SIGNED_EN
    return {31'd0, raw[15]};
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r = r | ((t % 10) << (4 * i));
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] ndig(input int v);
    int n;
    int t;
    n = 1;
    t = v / 10;
    while (t > 0) begin
      n++;
      t = t / 10;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge scan_clk);
    #1;
  endtask

  // Presents one write for exactly one active edge; returns 1ns after that edge.
  task automatic wr(input logic [15:0] v);
    scan_cs    = 1'b1;
    scan_write = 1'b1;
    scanwdata  = v;
    tick();
    scan_cs    = 1'b0;
    scan_write = 1'b0;
  endtask

  // Waits for the next bcd_valid pulse, counting cycles and busy-low samples before it.
  task automatic wait_valid(output int lat, output int blo);
    bit found;
    found = 0;
    lat = 0;
    blo = busy ? 0 : 1;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      lat++;
      if (bcd_valid) found = 1;
      else if (!busy) blo++;
    end
    if (!found) check("pulse_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_pulse(input string tag, input logic [15:0] raw, input int lat_exp);
    int lat;
    int blo;
    wait_valid(lat, blo);
    check({tag, "_lat"}, lat, lat_exp);
    check({tag, "_busy_gap"}, blo, 0);
    check({tag, "_bcd"}, {12'd0, bcd}, to_bcd(mag_of(raw)));
    check({tag, "_nz"}, {29'd0, nz_digits}, ndig(mag_of(raw)));
    check({tag, "_neg"}, {31'd0, neg}, neg_of(raw));
  endtask

  task automatic quiet(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      tick();
      if (bcd_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_valid"}, {31'd0, bcd_valid}, 0);
    check({tag, "_bcd"}, {12'd0, bcd}, 0);
    check({tag, "_nz"}, {29'd0, nz_digits}, 1);
    check({tag, "_neg"}, {31'd0, neg}, 0);
  endtask

  initial begin
    logic [15:0] a, b, c, v;

    repeat (3) @(posedge scan_clk);
    #1;
    check_reset_vals("rst");
    scan_rst = 1'b0;
    tick();

    // Zero: 16-cycle latency, busy for exactly 16 cycles, one-cycle pulse.
    wr(16'd0);
    expect_pulse("zero", 16'd0, 16);
    check("zero_busy_at_done", {31'd0, busy}, 0);
    tick();
    check("zero_pulse_width", {31'd0, bcd_valid}, 0);

    wr(16'hFFFF);
    expect_pulse("max", 16'hFFFF, 16);
    tick();
    wr(16'd509);
    expect_pulse("v509", 16'd509, 16);
    tick();

    for (int i = 0; i < 10; i++) begin
      v = 16'($urandom_range(0, 65535));
      wr(v);
      expect_pulse("rand", v, 16);
      tick();
    end

    // Writes during SHIFT: only the latest pending value survives.
    for (int it = 0; it < 2; it++) begin
      a = (it == 0) ? 16'd123 : 16'($urandom_range(0, 65535));
      b = (it == 0) ? 16'd456 : 16'($urandom_range(0, 65535));
      c = (it == 0) ? 16'd789 : 16'($urandom_range(0, 65535));
      wr(a);
      repeat (4) tick();
      wr(b);
      repeat (3) tick();
      wr(c);
      expect_pulse("pend_first", a, 7);
      expect_pulse("pend_last", c, 16);
      quiet("pend_no_third", 24);
      check("pend_idle_busy", {31'd0, busy}, 0);
    end

    // Write exactly on the completion edge, with and without a pending value.
    for (int it = 0; it < 2; it++) begin
      wr(16'd10);
      if (it == 0) begin
        repeat (15) tick();
      end else begin
        repeat (4) tick();
        wr(16'd77);
        repeat (10) tick();
      end
      wr(16'd42);
      check("edge_valid", {31'd0, bcd_valid}, 1);
      check("edge_bcd", {12'd0, bcd}, to_bcd(10));
      expect_pulse("edge_next", 16'd42, 16);
      quiet("edge_no_third", 24);
    end

    // Reset mid-conversion aborts without presenting a result.
    wr(16'd999);
    repeat (7) tick();
    scan_rst = 1'b1;
    #1;
    check_reset_vals("abort");
    tick();
    scan_rst = 1'b0;
    quiet("abort_no_pulse", 24);
    check("abort_busy", {31'd0, busy}, 0);
    wr(16'd7);
    expect_pulse("after_abort", 16'd7, 16);
    tick();

`ifdef SCAN_BCD_SIGNED_EN
    wr(16'hFFFF);
    expect_pulse("s_m1", 16'hFFFF, 16);
    tick();
    wr(16'h8000);
    expect_pulse("s_min", 16'h8000, 16);
    tick();
    wr(16'h0005);
    expect_pulse("s_pos", 16'h0005, 16);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
